multicycle_control_fsm: RTL and testbench

- Main control unit for the multicycle RISC-V core; sits directly upstream of the datapath.
- Takes the latched instruction (IR) and the ALU zero flag from the datapath.
- Drives the datapath's write strobes and mux selects state by state.
- Supports lw, sw, add, sub, addi and beq; waits on memory readiness; counts retired instructions; flags illegal encodings.

---
 rtl/multicycle_control_fsm.sv | 168 ++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle RISC-V core: sequences the datapath
// strobes and mux selects for lw, sw, add, sub, addi and beq.
module multicycle_control_fsm #(
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        instr,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_write,
  output logic               reg_write,
  output logic               ir_write,
  output logic               pc_write,
  output logic               instruction_or_data,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_control,
  output logic [3:0]         state,
  output logic               retire,
  output logic               illegal,
  output logic [COUNT_W-1:0] retire_count
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9
  } state_t;

  state_t state_q, state_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign funct7            = instr[31:25];
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};
  assign state             = state_q;

  // State register and retired-instruction counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_FETCH;
      retire_count <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retire_count <= retire_count + COUNT_W'(1);
    end
  end

  // Next-state decode and per-state datapath controls; reset forces all quiet
  always_comb begin
    state_d             = state_q;
    mem_write           = 1'b0;
    reg_write           = 1'b0;
    ir_write            = 1'b0;
    pc_write            = 1'b0;
    instruction_or_data = 1'b0;
    result_src          = 2'b00;
    alu_src_a           = 2'b00;
    alu_src_b           = 2'b00;
    alu_control         = 3'b000;
    retire              = 1'b0;
    illegal             = 1'b0;

    case (state_q)
      S_FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        pc_write  = 1'b1;
        alu_src_b = 2'b10;
        if ((opcode == OP_LOAD || opcode == OP_STORE) && funct3 == 3'b010)
          state_d = S_MEMADR;
        else if (opcode == OP_RTYPE && funct3 == 3'b000 &&
                 (funct7 == 7'b0000000 || funct7 == 7'b0100000))
          state_d = S_EXEC_R;
        else if (opcode == OP_ITYPE && funct3 == 3'b000)
          state_d = S_EXEC_I;
        else if (opcode == OP_BRANCH && funct3 == 3'b000)
          state_d = S_BEQ;
        else begin
          // PC already advanced, so the bad instruction is simply skipped
          illegal = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEMADR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        instruction_or_data = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a   = 2'b01;
        alu_control = funct7[5] ? 3'b001 : 3'b000;
        state_d     = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a   = 2'b01;
        alu_control = 3'b001;
        pc_write    = zero;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (!reset_n) begin
      mem_write           = 1'b0;
      reg_write           = 1'b0;
      ir_write            = 1'b0;
      pc_write            = 1'b0;
      instruction_or_data = 1'b0;
      result_src          = 2'b00;
      alu_src_a           = 2'b00;
      alu_src_b           = 2'b00;
      alu_control         = 3'b000;
      retire              = 1'b0;
      illegal             = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: each cycle's expected outputs
// are pushed to a scoreboard when inputs are driven and checked mid-cycle.
module tb_multicycle_control_fsm;

  localparam int unsigned CW = 4;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_LW   = 32'h00802283;
  localparam logic [31:0] I_SW   = 32'h00202223;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_JAL  = 32'h0000006F;
  localparam logic [31:0] I_BADF = 32'h002091B3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [31:0]   instr;
  logic          zero;
  logic          mem_ready;
  logic          mem_write, reg_write, ir_write, pc_write, instruction_or_data;
  logic [1:0]    result_src, alu_src_a, alu_src_b;
  logic [2:0]    alu_control;
  logic [3:0]    state;
  logic          retire, illegal;
  logic [CW-1:0] retire_count;

  typedef struct packed {
    logic [3:0] st;
    logic       mw, rw, iw, pw, iod;
    logic [1:0] rs, a, b;
    logic [2:0] alu;
    logic       ret, ill;
  } obs_t;

  typedef struct packed {
    obs_t          o;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb[$];
  int            total = 0;
  int            bad = 0;
  logic [CW-1:0] model_cnt = '0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.COUNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .instr(instr), .zero(zero),
    .mem_ready(mem_ready), .mem_write(mem_write), .reg_write(reg_write),
    .ir_write(ir_write), .pc_write(pc_write),
    .instruction_or_data(instruction_or_data), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .state(state), .retire(retire), .illegal(illegal),
    .retire_count(retire_count)
  );

  function automatic logic legal(input logic [31:0] i);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = i[6:0];
    f3 = i[14:12];
    f7 = i[31:25];
    case (op)
      7'b0000011, 7'b0100011: return f3 == 3'b010;
      7'b0110011: return f3 == 3'b000 && (f7 == 7'b0000000 || f7 == 7'b0100000);
      7'b0010011, 7'b1100011: return f3 == 3'b000;
      default: return 1'b0;
    endcase
  endfunction

  // Expected output decode for a given state, from the control table
  function automatic obs_t spec_out(input logic [3:0] st, input logic [31:0] i,
                                    input logic z, input logic mr);
    obs_t e;
    e = '0;
    e.st = st;
    case (st)
      4'd0: begin e.b = 2'b01; e.iw = mr; end
      4'd1: begin e.pw = 1'b1; e.b = 2'b10; e.ill = !legal(i); end
      4'd2: begin e.a = 2'b01; e.b = 2'b10; end
      4'd3: e.iod = 1'b1;
      4'd4: begin e.rs = 2'b01; e.rw = 1'b1; e.ret = 1'b1; end
      4'd5: begin e.mw = 1'b1; e.ret = 1'b1; end
      4'd6: begin e.a = 2'b01; e.alu = i[30] ? 3'b001 : 3'b000; end
      4'd7: begin e.a = 2'b01; e.b = 2'b10; end
      4'd8: begin e.rw = 1'b1; e.ret = 1'b1; end
      4'd9: begin e.a = 2'b01; e.alu = 3'b001; e.pw = z; e.ret = 1'b1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  // One clock cycle: drive inputs, record expectation, check at negedge
  task automatic step(input logic [31:0] i, input logic z, input logic mr,
                      input logic rn, input logic [3:0] st);
    exp_t e, got;
    obs_t obs;
    @(posedge clk);
    #1;
    instr     = i;
    zero      = z;
    mem_ready = mr;
    reset_n   = rn;
    e.o = '0;
    e.o.st = st;
    if (rn) e.o = spec_out(st, i, z, mr);
    e.cnt = model_cnt;
    sb.push_back(e);
    if (!rn) model_cnt = '0;
    else if (e.o.ret) model_cnt = model_cnt + CW'(1);
    @(negedge clk);
    obs = {state, mem_write, reg_write, ir_write, pc_write, instruction_or_data,
           result_src, alu_src_a, alu_src_b, alu_control, retire, illegal};
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty got=%h want=entry", obs);
    end else begin
      got = sb.pop_front();
      assert (obs === got.o) else begin
        bad++;
        $error("FAIL outputs st=%0d got=%h want=%h", st, obs, got.o);
      end
      total++;
      assert (retire_count === got.cnt) else begin
        bad++;
        $error("FAIL retire_count st=%0d got=%0d want=%0d", st, retire_count, got.cnt);
      end
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    instr     = '0;
    zero      = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    step(I_ADD, 0, 1, 0, 4'd0);

    // add, then sub
    step(I_ADD, 0, 1, 1, 4'd0); step(I_ADD, 0, 1, 1, 4'd1);
    step(I_ADD, 0, 1, 1, 4'd6); step(I_ADD, 0, 1, 1, 4'd8);
    step(I_SUB, 0, 1, 1, 4'd0); step(I_SUB, 0, 1, 1, 4'd1);
    step(I_SUB, 0, 1, 1, 4'd6); step(I_SUB, 0, 1, 1, 4'd8);

    // lw with two memory wait cycles
    step(I_LW, 0, 1, 1, 4'd0); step(I_LW, 0, 1, 1, 4'd1);
    step(I_LW, 0, 1, 1, 4'd2); step(I_LW, 0, 0, 1, 4'd3);
    step(I_LW, 0, 0, 1, 4'd3); step(I_LW, 0, 1, 1, 4'd3);
    step(I_LW, 0, 1, 1, 4'd4);

    // beq taken after a fetch stall, then not taken
    step(I_BEQ, 1, 0, 1, 4'd0); step(I_BEQ, 1, 1, 1, 4'd0);
    step(I_BEQ, 1, 1, 1, 4'd1); step(I_BEQ, 1, 1, 1, 4'd9);
    step(I_BEQ, 0, 1, 1, 4'd0); step(I_BEQ, 0, 1, 1, 4'd1);
    step(I_BEQ, 0, 1, 1, 4'd9);

    // sw
    step(I_SW, 0, 1, 1, 4'd0); step(I_SW, 0, 1, 1, 4'd1);
    step(I_SW, 0, 1, 1, 4'd2); step(I_SW, 0, 1, 1, 4'd5);

    // illegal encodings
    step(I_JAL, 0, 1, 1, 4'd0);  step(I_JAL, 0, 1, 1, 4'd1);
    step(I_BADF, 0, 1, 1, 4'd0); step(I_BADF, 0, 1, 1, 4'd1);

    // reset in the middle of a lw memory wait
    step(I_LW, 0, 1, 1, 4'd0); step(I_LW, 0, 1, 1, 4'd1);
    step(I_LW, 0, 1, 1, 4'd2); step(I_LW, 0, 0, 1, 4'd3);
    step(I_LW, 0, 0, 0, 4'd3); step(I_LW, 0, 0, 0, 4'd0);
    step(I_LW, 0, 0, 0, 4'd0);

    // restart, then 16 retires wrap the 4-bit count back to 0
    step(I_ADD, 0, 1, 1, 4'd0); step(I_ADD, 0, 1, 1, 4'd1);
    step(I_ADD, 0, 1, 1, 4'd6); step(I_ADD, 0, 1, 1, 4'd8);
    for (int k = 0; k < 15; k++) begin
      step(I_ADDI, 0, 1, 1, 4'd0); step(I_ADDI, 0, 1, 1, 4'd1);
      step(I_ADDI, 0, 1, 1, 4'd7); step(I_ADDI, 0, 1, 1, 4'd8);
    end
    step(I_ADD, 0, 1, 1, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
